// File: rtl/jitter_clk_gen_pkg.sv
// Shared types and constants for the jittered clock generator.
package jitter_clk_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // One Galois right-shift step of the 16-bit LFSR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/jitter_clk_gen_if.sv
// Bundle of enable/status signals for jitter_clk_gen.
// Optional seed loading ports appear when JITTER_CLK_GEN_SEED_LOAD_EN is defined.
interface jitter_clk_gen_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             running;
  logic             clk_out;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] half_period;
`ifdef JITTER_CLK_GEN_SEED_LOAD_EN
  logic             seed_load;
  logic [15:0]      seed_val;

  modport master (output en, seed_load, seed_val,
                  input  running, clk_out, rise, fall, half_period);
  modport slave  (input  en, seed_load, seed_val,
                  output running, clk_out, rise, fall, half_period);
`else
  modport master (output en,
                  input  running, clk_out, rise, fall, half_period);
  modport slave  (input  en,
                  output running, clk_out, rise, fall, half_period);
`endif
endinterface

// File: rtl/jcg_lfsr.sv
// 16-bit Galois LFSR with explicit advance and load controls.
module jcg_lfsr
  import jitter_clk_gen_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] value
);

  logic [15:0] lfsr_r;

  // LFSR state: reset to SEED, load has priority over advance, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r <= SEED;
    end else if (load) begin
      lfsr_r <= load_val;
    end else if (advance) begin
      lfsr_r <= lfsr_next(lfsr_r);
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  assign value = lfsr_r;

endmodule

// File: rtl/jitter_clk_gen.sv
// Jittered divided clock source: each half-period of clk_out is
// MIN_HALF + (random 0 .. 2**JITTER_BITS-1) system clocks long.
// A high phase is always completed before stopping, so no runt highs.
// Optional feature macro: JITTER_CLK_GEN_SEED_LOAD_EN (runtime seed load in IDLE).
module jitter_clk_gen
  import jitter_clk_gen_pkg::*;
#(
  parameter int          MIN_HALF    = 4,
  parameter int          JITTER_BITS = 3,
  parameter int          CNT_W       = 8,
  parameter int          LFSR_W      = 16,
  parameter logic [15:0] SEED        = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             rst,
  jitter_clk_gen_if.slave  bus
);

  localparam int MAX_HALF = MIN_HALF + (1 << JITTER_BITS) - 1;

  // Elaboration-time parameter sanity checks.
  generate
    if (MIN_HALF < 1) begin : g_err_min_half
      $error("jitter_clk_gen: MIN_HALF must be >= 1");
    end
    if (MAX_HALF >= (1 << CNT_W)) begin : g_err_cnt_w
      $error("jitter_clk_gen: maximum half-period does not fit in CNT_W bits");
    end
    if (SEED == 16'h0000) begin : g_err_seed
      $error("jitter_clk_gen: SEED must be non-zero");
    end
    if (LFSR_W != 16) begin : g_err_lfsr_w
      $error("jitter_clk_gen: only LFSR_W == 16 is supported");
    end
  endgenerate

  state_t           state_r, state_n;
  logic [CNT_W-1:0] cnt_r, cnt_n;
  logic [CNT_W-1:0] half_r, half_n;
  logic             clk_out_r, clk_out_n;
  logic             running_r, running_n;
  logic             rise_r, rise_n;
  logic             fall_r, fall_n;
  logic             load_s;
  logic             seed_req_s;
  logic             seed_load_s;
  logic [15:0]      seed_mux_s;
  logic [15:0]      lfsr_s;
  logic [CNT_W-1:0] h_s;
  logic             unused_lfsr_bits_s;

`ifdef JITTER_CLK_GEN_SEED_LOAD_EN
  assign seed_req_s = bus.seed_load;
  assign seed_mux_s = (bus.seed_val == 16'h0000) ? SEED : bus.seed_val;
`else
  assign seed_req_s = 1'b0;
  assign seed_mux_s = SEED;
`endif

  // Length of the next phase, taken from the LFSR value present at load time.
  assign h_s = CNT_W'(MIN_HALF) + CNT_W'(lfsr_s[JITTER_BITS-1:0]);
  assign unused_lfsr_bits_s = ^lfsr_s;

  jcg_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .advance  (load_s),
    .load     (seed_load_s),
    .load_val (seed_mux_s),
    .value    (lfsr_s)
  );

  // Next-state and next-output logic for the IDLE/LOW/HIGH sequencer.
  always_comb begin
    state_n     = state_r;
    cnt_n       = cnt_r;
    half_n      = half_r;
    clk_out_n   = clk_out_r;
    running_n   = running_r;
    rise_n      = 1'b0;
    fall_n      = 1'b0;
    load_s      = 1'b0;
    seed_load_s = 1'b0;
    case (state_r)
      IDLE: begin
        clk_out_n = 1'b0;
        if (seed_req_s) begin
          // Seed load wins; a pending start happens on the following edge.
          seed_load_s = 1'b1;
        end else if (bus.en) begin
          load_s    = 1'b1;
          cnt_n     = h_s - CNT_W'(1);
          half_n    = h_s;
          running_n = 1'b1;
          state_n   = LOW;
        end else begin
          state_n = IDLE;
        end
      end
      LOW: begin
        if (!bus.en) begin
          // Output is already low, so stopping here cannot glitch.
          state_n   = IDLE;
          running_n = 1'b0;
          half_n    = {CNT_W{1'b0}};
          cnt_n     = {CNT_W{1'b0}};
        end else if (cnt_r == {CNT_W{1'b0}}) begin
          clk_out_n = 1'b1;
          rise_n    = 1'b1;
          load_s    = 1'b1;
          cnt_n     = h_s - CNT_W'(1);
          half_n    = h_s;
          state_n   = HIGH;
        end else begin
          cnt_n = cnt_r - CNT_W'(1);
        end
      end
      HIGH: begin
        // en is only looked at once the high phase has fully elapsed.
        if (cnt_r == {CNT_W{1'b0}}) begin
          clk_out_n = 1'b0;
          fall_n    = 1'b1;
          if (bus.en) begin
            load_s  = 1'b1;
            cnt_n   = h_s - CNT_W'(1);
            half_n  = h_s;
            state_n = LOW;
          end else begin
            running_n = 1'b0;
            half_n    = {CNT_W{1'b0}};
            state_n   = IDLE;
          end
        end else begin
          cnt_n = cnt_r - CNT_W'(1);
        end
      end
      default: begin
        state_n   = IDLE;
        cnt_n     = {CNT_W{1'b0}};
        half_n    = {CNT_W{1'b0}};
        clk_out_n = 1'b0;
        running_n = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      half_r    <= {CNT_W{1'b0}};
      clk_out_r <= 1'b0;
      running_r <= 1'b0;
      rise_r    <= 1'b0;
      fall_r    <= 1'b0;
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      half_r    <= half_n;
      clk_out_r <= clk_out_n;
      running_r <= running_n;
      rise_r    <= rise_n;
      fall_r    <= fall_n;
    end
  end

  assign bus.running     = running_r;
  assign bus.clk_out     = clk_out_r;
  assign bus.rise        = rise_r;
  assign bus.fall        = fall_r;
  assign bus.half_period = half_r;

endmodule

// File: tb/tb_jitter_clk_gen.sv
// Directed, table-driven bench for jitter_clk_gen (default parameters).
module tb_jitter_clk_gen;

  typedef struct {
    logic       en;
    logic       rst;
    logic       clk_out;
    logic       running;
    logic       rise;
    logic       fall;
    logic [7:0] half;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t tbl[$];

  jitter_clk_gen_if #(.CNT_W(8)) bus ();

  jitter_clk_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something stalls.
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic e, input logic r, input logic c,
                              input logic run, input logic ri, input logic f,
                              input logic [7:0] h);
    vec_t v;
    v.en = e; v.rst = r; v.clk_out = c; v.running = run;
    v.rise = ri; v.fall = f; v.half = h;
    return v;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply inputs, clock once, sample 1 time unit after the edge.
  task automatic tick(input logic en_v, input logic rst_v);
    bus.en = en_v;
    rst    = rst_v;
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input int start);
    for (int i = start; i < tbl.size(); i++) begin
      tick(tbl[i].en, tbl[i].rst);
      chk1($sformatf("vec%0d.clk_out", i), bus.clk_out, tbl[i].clk_out);
      chk1($sformatf("vec%0d.running", i), bus.running, tbl[i].running);
      chk1($sformatf("vec%0d.rise", i), bus.rise, tbl[i].rise);
      chk1($sformatf("vec%0d.fall", i), bus.fall, tbl[i].fall);
      chk8($sformatf("vec%0d.half", i), bus.half_period, tbl[i].half);
    end
  endtask

  initial begin
    int   phases;
    int   len;
    int   exp_len;
    logic prev_clk;
    logic prev_run;

    rst    = 1'b1;
    bus.en = 1'b0;
`ifdef JITTER_CLK_GEN_SEED_LOAD_EN
    bus.seed_load = 1'b0;
    bus.seed_val  = 16'h0000;
`endif

    // Reset, then en held: half periods 5,4,4,8 then 10 from SEED 16'hACE1.
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    repeat (5) tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd5));
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd4));
    repeat (3) tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd4));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd4));
    repeat (3) tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4));
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd8));
    repeat (7) tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd8));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd10));

    run_table(0);

    // en dropped in the second cycle of the first HIGH phase.
    tick(1'b0, 1'b1);
    repeat (6) tick(1'b1, 1'b0);
    chk1("hi_drop.pre_clk", bus.clk_out, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0);
      chk1($sformatf("hi_drop.hold%0d", k), bus.clk_out, 1'b1);
      chk1($sformatf("hi_drop.run%0d", k), bus.running, 1'b1);
      chk1($sformatf("hi_drop.fall%0d", k), bus.fall, 1'b0);
    end
    tick(1'b0, 1'b0);
    chk1("hi_drop.clk_out", bus.clk_out, 1'b0);
    chk1("hi_drop.fall", bus.fall, 1'b1);
    chk1("hi_drop.running", bus.running, 1'b0);
    chk8("hi_drop.half", bus.half_period, 8'd0);
    tick(1'b0, 1'b0);
    chk1("hi_drop.fall_once", bus.fall, 1'b0);
    chk1("hi_drop.rise_after", bus.rise, 1'b0);

    // en dropped in the middle of the first LOW phase.
    tick(1'b0, 1'b1);
    repeat (3) tick(1'b1, 1'b0);
    chk1("lo_drop.pre_run", bus.running, 1'b1);
    tick(1'b0, 1'b0);
    chk1("lo_drop.running", bus.running, 1'b0);
    chk8("lo_drop.half", bus.half_period, 8'd0);
    for (int k = 0; k < 6; k++) begin
      chk1($sformatf("lo_drop.clk%0d", k), bus.clk_out, 1'b0);
      chk1($sformatf("lo_drop.rise%0d", k), bus.rise, 1'b0);
      tick(1'b0, 1'b0);
    end

    // Reset while clk_out is high, then the sequence must repeat from SEED.
    tick(1'b0, 1'b1);
    repeat (6) tick(1'b1, 1'b0);
    chk1("rst_hi.pre_clk", bus.clk_out, 1'b1);
    tick(1'b1, 1'b1);
    chk1("rst_hi.clk_out", bus.clk_out, 1'b0);
    chk1("rst_hi.running", bus.running, 1'b0);
    chk1("rst_hi.rise", bus.rise, 1'b0);
    chk1("rst_hi.fall", bus.fall, 1'b0);
    chk8("rst_hi.half", bus.half_period, 8'd0);
    run_table(1);

    // Long run: range of every half period, exact pulse alignment, phase length.
    tick(1'b0, 1'b1);
    phases   = 0;
    len      = 0;
    exp_len  = 0;
    prev_clk = 1'b0;
    prev_run = 1'b0;
    for (int cyc = 0; cyc < 20000 && phases < 1000; cyc++) begin
      tick(1'b1, 1'b0);
      if (bus.running && !prev_run) begin
        exp_len = int'(bus.half_period);
        len     = 1;
      end else if (bus.rise || bus.fall) begin
        chki("long.phase_len", len, exp_len);
        phases++;
        exp_len = int'(bus.half_period);
        len     = 1;
      end else begin
        len++;
      end
      chk1("long.rise_edge", bus.rise, bus.clk_out & ~prev_clk);
      chk1("long.fall_edge", bus.fall, ~bus.clk_out & prev_clk);
      chk1("long.half_range",
           (bus.half_period >= 8'd4) && (bus.half_period <= 8'd11), 1'b1);
      prev_clk = bus.clk_out;
      prev_run = bus.running;
    end
    chk1("long.phase_count", phases >= 1000, 1'b1);

`ifdef JITTER_CLK_GEN_SEED_LOAD_EN
    // Seed load has priority over a start on the same edge.
    tick(1'b0, 1'b1);
    bus.seed_load = 1'b1;
    bus.seed_val  = 16'h0007;
    tick(1'b1, 1'b0);
    chk1("seed7.no_start", bus.running, 1'b0);
    bus.seed_load = 1'b0;
    tick(1'b1, 1'b0);
    chk1("seed7.running", bus.running, 1'b1);
    chk8("seed7.half", bus.half_period, 8'd11);
    tick(1'b0, 1'b0);
    chk1("seed7.stop", bus.running, 1'b0);
    // Zero seed value falls back to SEED.
    bus.seed_load = 1'b1;
    bus.seed_val  = 16'h0000;
    tick(1'b0, 1'b0);
    bus.seed_load = 1'b0;
    tick(1'b1, 1'b0);
    chk1("seed0.running", bus.running, 1'b1);
    chk8("seed0.half", bus.half_period, 8'd5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
